// File: rtl/rb_arb_pkg.sv
// Shared types and constants for the register-bank arbiter.
package rb_arb_pkg;
  localparam int NREQ        = 3;
  localparam int GW          = 2;
  localparam int AW          = 4;
  localparam int DW          = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
    return (g == GW'(NREQ - 1)) ? '0 : g + GW'(1);
  endfunction

  // First pending requester strictly after 'last', wrapping around.
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] pend,
                                            input logic [GW-1:0]   last);
    logic [GW-1:0] c;
    logic [GW-1:0] sel;
    logic          found;
    c     = last;
    sel   = last;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      c = rr_next(c);
      if (!found && pend[c]) begin
        sel   = c;
        found = 1'b1;
      end
    end
    return sel;
  endfunction
endpackage

// File: rtl/rb_arbiter_tgl_sync.sv
// Two-flop synchroniser for one asynchronous request toggle.
module tgl_sync (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/rb_arbiter.sv
// Round-robin arbiter: three toggle-handshake requesters share one register-bank port.
// Only one bank transaction is in flight; a silent bank is cut off after TIMEOUT cycles.
module rb_arbiter
  import rb_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req_tgl,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    ack_tgl,
  output logic [NREQ*DW-1:0] rsp_data,
  output logic               err,
  output logic               rb_req,
  output logic               rb_we,
  output logic [AW-1:0]      rb_addr,
  output logic [DW-1:0]      rb_wdata,
  input  logic               rb_ack,
  input  logic [DW-1:0]      rb_rdata
);
  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [GW-1:0]             r_grant;
  logic [GW-1:0]             r_last;
  logic [7:0]                r_cnt;
  logic [NREQ-1:0]           w_sync;
  logic [NREQ-1:0]           w_pend;
  logic [NREQ-1:0][AW-1:0]   w_addr_a;
  logic [NREQ-1:0][DW-1:0]   w_wdata_a;
  logic                      w_cnt_hit;
  logic                      w_grab;
  logic                      w_issue;
  logic                      w_ack_hit;
  logic                      w_to_hit;
  logic                      w_done;

  assign w_addr_a  = req_addr;
  assign w_wdata_a = req_wdata;
  assign w_pend    = w_sync ^ ack_tgl;
  assign w_cnt_hit = ({1'b0, r_cnt} + 9'd1) >= TO_LIM;
  assign w_done    = w_ack_hit | w_to_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (|w_pend) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (rb_ack || w_cnt_hit) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // rb_ack is only looked at in WAIT; an ack landing with the timeout wins.
  always_comb begin
    w_grab    = 1'b0;
    w_issue   = 1'b0;
    w_ack_hit = 1'b0;
    w_to_hit  = 1'b0;
    unique case (r_state)
      IDLE:  w_grab = |w_pend;
      ISSUE: w_issue = 1'b1;
      WAIT: begin
        w_ack_hit = rb_ack;
        w_to_hit  = !rb_ack && w_cnt_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_grant  <= '0;
      r_last   <= GW'(NREQ - 1);
      r_cnt    <= '0;
      rb_req   <= 1'b0;
      rb_we    <= 1'b0;
      rb_addr  <= '0;
      rb_wdata <= '0;
      err      <= 1'b0;
    end else begin
      rb_req <= w_issue;
      if (w_grab) r_grant <= rr_pick(w_pend, r_last);
      if (w_issue) begin
        rb_we    <= req_we[r_grant];
        rb_addr  <= w_addr_a[r_grant];
        rb_wdata <= w_wdata_a[r_grant];
        r_cnt    <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_done)   r_last <= r_grant;
      if (w_to_hit) err    <= 1'b1;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    logic          r_ack;
    logic [DW-1:0] r_rsp;

    tgl_sync u_sync (
      .clk    (clk),
      .resetn (resetn),
      .i_d    (req_tgl[i]),
      .o_q    (w_sync[i])
    );

    // A timed-out read returns zero so the requester never sees stale data.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_ack <= 1'b0;
        r_rsp <= '0;
      end else if (w_done && (r_grant == GW'(i))) begin
        r_ack <= ~r_ack;
        if (!rb_we) r_rsp <= w_ack_hit ? rb_rdata : '0;
      end
    end

    assign ack_tgl[i]             = r_ack;
    assign rsp_data[i*DW +: DW]   = r_rsp;
  end
endmodule
